translater_stim_p: RTL and testbench

Parametrised, synthesizable stimulus sequencer for the translater datapath. Generalises the fixed two-input probe sequence (enable held low, data phase, selector pulse, stop) to NUM_CH channels of WIDTH-bit data, with programmable phase lengths and four data-pattern modes. It sits in front of the translater in benches and self-test wrappers: it drives ENB, per-channel data and per-channel selectors, and reports busy/done.

---
 rtl/translater_stim_p.sv | 173 +++++++++++++++++
 tb/tb_translater_stim_p.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/translater_stim_p.sv
// Stimulus sequencer for the translater: holds ENB low, plays NUM_CH pattern
// streams, pulses the selectors, then flags done. All outputs are registered.
module translater_stim_p #(
  parameter int NUM_CH     = 2,
  parameter int WIDTH      = 8,
  parameter int ENB_DELAY  = 2,
  parameter int RUN_CYCLES = 4,
  parameter int SEL_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        seed,
  output logic                    ENB,
  output logic [NUM_CH*WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]       selector,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_A   = (ENB_DELAY > RUN_CYCLES) ? ENB_DELAY : RUN_CYCLES;
  localparam int MAX_LEN = (MAX_A > SEL_CYCLES) ? MAX_A : SEL_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] ENB_LAST = CW'(ENB_DELAY - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] SEL_LAST = CW'(SEL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ENB,
    S_RUN,
    S_SEL,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [1:0]                mode_q, mode_d;
  logic [WIDTH-1:0]          seed_q, seed_d;
  logic                      enb_q, enb_d;
  logic [NUM_CH*WIDTH-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]         sel_q, sel_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  // Step-0 value of channel c; channel index wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] pat_init(input logic [1:0] m,
                                                input logic [WIDTH-1:0] s,
                                                input int c);
    logic [WIDTH-1:0] cv;
    logic [WIDTH-1:0] v;
    cv = WIDTH'(c);
    case (m)
      2'd0, 2'd1: v = s + cv;
      2'd2: begin
        v = s ^ cv;
        if (v == '0) v = WIDTH'(1);
      end
      default: v = WIDTH'(1) << (c % WIDTH);
    endcase
    return v;
  endfunction

  // Advance one pattern step; walking-one is a rotate-left.
  function automatic logic [WIDTH-1:0] pat_step(input logic [1:0] m,
                                                input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] v;
    case (m)
      2'd0:    v = x;
      2'd1:    v = x + WIDTH'(1);
      2'd2:    v = {x[WIDTH-2:0], x[WIDTH-1] ^ x[WIDTH-2]};
      default: v = {x[WIDTH-2:0], x[WIDTH-1]};
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    seed_d  = seed_q;
    enb_d   = enb_q;
    data_d  = data_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_ENB;
          cnt_d   = '0;
          mode_d  = mode;
          seed_d  = seed;
          enb_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_WAIT_ENB: begin
        if (cnt_q == ENB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          enb_d   = 1'b1;
          for (int c = 0; c < NUM_CH; c++)
            data_d[c*WIDTH +: WIDTH] = pat_init(mode_q, seed_q, c);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          state_d = S_SEL;
          cnt_d   = '0;
          sel_d   = '1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          for (int c = 0; c < NUM_CH; c++)
            data_d[c*WIDTH +: WIDTH] = pat_step(mode_q, data_q[c*WIDTH +: WIDTH]);
        end
      end
      S_SEL: begin
        if (cnt_q == SEL_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          sel_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      seed_q  <= '0;
      enb_q   <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      enb_q   <= enb_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ENB      = enb_q;
  assign data_out = data_q;
  assign selector = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_translater_stim_p.sv
// Bench for translater_stim_p: directed and random sequences on a default
// instance plus a WIDTH=4/RUN_CYCLES=6 instance for walking-one wrap.
module tb_translater_stim_p;

  localparam int D = 2;
  localparam int R = 4;
  localparam int S = 1;
  localparam int W = 8;
  localparam int N = 2;
  localparam int WW = 4;
  localparam int RW = 6;

  logic           clk = 1'b0;
  logic           reset_L = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [W-1:0]   seed = '0;
  logic           ENB;
  logic [N*W-1:0] data_out;
  logic [N-1:0]   selector;
  logic           busy, done;

  logic            start_w = 1'b0;
  logic [1:0]      mode_w = 2'd0;
  logic [WW-1:0]   seed_w = '0;
  logic            ENB_w;
  logic [N*WW-1:0] data_out_w;
  logic [N-1:0]    selector_w;
  logic            busy_w, done_w;

  int tests = 0;
  int fails = 0;

  translater_stim_p #(.NUM_CH(N), .WIDTH(W), .ENB_DELAY(D), .RUN_CYCLES(R), .SEL_CYCLES(S)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .mode(mode), .seed(seed),
    .ENB(ENB), .data_out(data_out), .selector(selector), .busy(busy), .done(done));

  translater_stim_p #(.NUM_CH(N), .WIDTH(WW), .ENB_DELAY(D), .RUN_CYCLES(RW), .SEL_CYCLES(S)) dut_w (
    .clk(clk), .reset_L(reset_L), .start(start_w), .mode(mode_w), .seed(seed_w),
    .ENB(ENB_w), .data_out(data_out_w), .selector(selector_w), .busy(busy_w), .done(done_w));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel c, step k, straight from the pattern definitions.
  function automatic logic [63:0] ref_ch(input int unsigned m, input int unsigned s,
                                         input int unsigned c, input int unsigned w,
                                         input int unsigned k);
    int unsigned mask;
    int unsigned x;
    mask = (32'd1 << w) - 1;
    case (m)
      0: x = (s + c) & mask;
      1: x = (s + c + k) & mask;
      2: begin
        x = (s ^ c) & mask;
        if (x == 0) x = 1;
        for (int unsigned j = 0; j < k; j++)
          x = ((x << 1) | (((x >> (w - 1)) ^ (x >> (w - 2))) & 1)) & mask;
      end
      default: x = 32'd1 << ((c + k) % w);
    endcase
    return 64'(x);
  endfunction

  function automatic logic [63:0] exp_data(input int unsigned m, input int unsigned s,
                                           input int unsigned w, input int unsigned k);
    logic [63:0] v;
    v = '0;
    for (int unsigned c = 0; c < N; c++)
      v = v | (ref_ch(m, s, c, w, k) << (c * w));
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_enb"},  64'(ENB), 64'd0);
    chk({tag, "_data"}, 64'(data_out), 64'd0);
    chk({tag, "_sel"},  64'(selector), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Runs one sequence on dut, checking each cycle after the start edge.
  task automatic run_seq(input logic [1:0] m, input logic [W-1:0] s,
                         input int pulse_i, input bit hold);
    @(negedge clk);
    mode = m; seed = s; start = 1'b1;
    @(negedge clk);
    start = hold;
    mode = 2'($urandom);
    seed = W'($urandom);
    for (int i = 0; i <= D + R + S + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (i < D) begin
        chk("wait_enb", 64'(ENB), 64'd0);
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_sel", 64'(selector), 64'd0);
      end else if (i < D + R) begin
        chk("run_data", 64'(data_out), exp_data(m, s, W, i - D));
        chk("run_enb", 64'(ENB), 64'd1);
        chk("run_busy", 64'(busy), 64'd1);
        if (m == 2'd2)
          for (int c = 0; c < N; c++)
            chk("lfsr_zero", 64'(data_out[c*W +: W] == '0), 64'd0);
      end else if (i < D + R + S) begin
        chk("sel_sel", 64'(selector), 64'h3);
        chk("sel_data", 64'(data_out), exp_data(m, s, W, R - 1));
        chk("sel_done", 64'(done), 64'd0);
      end else if (i == D + R + S) begin
        chk("done_done", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_sel", 64'(selector), 64'd0);
      end else begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_enb", 64'(ENB), 64'd1);
      end
      if (!hold) start = (i == pulse_i);
    end
  endtask

  initial begin
    #2 reset_L = 1'b0;
    #1 chk_zero("reset_init");
    repeat (2) @(negedge clk);
    reset_L = 1'b1;

    run_seq(2'd1, 8'h10, -1, 1'b0);
    chk("inc10_ch0_step3", 64'(data_out[7:0]), 64'h13);
    chk("inc10_ch1_step3", 64'(data_out[15:8]), 64'h14);
    run_seq(2'd1, 8'hFE, -1, 1'b0);
    chk("incFE_ch0_step3", 64'(data_out[7:0]), 64'h01);
    run_seq(2'd2, 8'h00, -1, 1'b0);
    chk("lfsr0_ch0_step3", 64'(data_out[7:0]), 64'h08);
    run_seq(2'd0, 8'h5A, -1, 1'b0);
    run_seq(2'd3, 8'hC3, -1, 1'b0);

    for (int n = 0; n < 6; n++)
      run_seq(2'($urandom), W'($urandom), -1, 1'b0);

    // start pulsed during RUN must not disturb the timeline
    run_seq(2'd1, W'($urandom), D + 1, 1'b0);
    @(negedge clk);
    chk("ignored_start_idle", 64'(busy), 64'd0);

    // start held high: one IDLE cycle, then a fresh sequence
    run_seq(2'd2, W'($urandom), -1, 1'b1);
    @(negedge clk);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_enb", 64'(ENB), 64'd0);
    start = 1'b0;
    repeat (D + R + S + 1) @(negedge clk);
    chk("b2b_end_busy", 64'(busy), 64'd0);
    chk("b2b_end_enb", 64'(ENB), 64'd1);

    // reset dropped mid-SEL clears outputs without a clock edge
    @(negedge clk);
    mode = 2'd1; seed = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (D + R) @(negedge clk);
    chk("pre_reset_sel", 64'(selector), 64'h3);
    #2 reset_L = 1'b0;
    #1 chk_zero("reset_sel");
    @(negedge clk);
    reset_L = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 64'(busy), 64'd0);
    run_seq(2'd1, 8'h20, -1, 1'b0);

    // walking-one wrap on the narrow instance
    @(negedge clk);
    mode_w = 2'd3; seed_w = WW'($urandom); start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    mode_w = 2'd1;
    repeat (D) @(negedge clk);
    for (int k = 0; k < RW; k++) begin
      chk("walk_data", 64'(data_out_w), exp_data(3, 0, WW, k));
      chk("walk_enb", 64'(ENB_w), 64'd1);
      @(negedge clk);
    end
    chk("walk_sel", 64'(selector_w), 64'h3);
    chk("walk_hold", 64'(data_out_w), 64'h42);
    @(negedge clk);
    chk("walk_done", 64'(done_w), 64'd1);
    @(negedge clk);
    chk("walk_idle", 64'(busy_w), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
